// File: rtl/sa_pkg.sv
// ============================================================================
// Module : sa_pkg
// Brief  : Shared types, operand counts and row-major index maps for the
//          2x2 systolic array loader and array.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } sa_state_e;

    localparam int N_A     = 16;
    localparam int N_B     = 9;
    localparam int N_BEATS = N_A + N_B;

    // Zero-based row/col to beat index; b operands follow the 16 a operands.
    function automatic int a_index(input int row, input int col);
        return row * 4 + col;
    endfunction

    function automatic int b_index(input int row, input int col);
        return N_A + row * 3 + col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sa_timeout_counter.sv
// ============================================================================
// Module : sa_timeout_counter
// Brief  : Clearable up-counter used to bound waits on a downstream block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sa_timeout_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/sa2_operand_loader.sv
// ============================================================================
// Module : sa2_operand_loader
// Brief  : Fills 16 data and 9 filter operands from a byte stream, then holds
//          them and drives active_sa2 until the array reports done_sa2.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sa2_operand_loader
    import sa_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [N_A*DW-1:0] a_flat,
    output logic [N_B*DW-1:0] b_flat,
    output logic              active_sa2,
    input  logic              done_sa2,
    output logic              busy,
    output logic              frame_err,
    output logic [7:0]        launch_cnt
);

    localparam int          IW       = $clog2(N_BEATS);
    localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_BEATS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    sa_state_e     state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] ops_q [N_BEATS];

    logic          in_ready_q, active_q, busy_q, frame_err_q;
    logic [7:0]    launch_cnt_q;

    logic          accept, we, err_d, done_inc, expired;
    logic [TW-1:0] run_cnt;

    assign accept  = in_valid && in_ready_q;
    assign expired = (run_cnt == TMO_LAST);

    // Counter sits at zero outside RUN, so every RUN visit starts from 0.
    sa_timeout_counter #(
        .WIDTH (TW)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q != ST_RUN),
        .en_i    (state_q == ST_RUN),
        .count_o (run_cnt)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we       = 1'b0;
        err_d    = 1'b0;
        done_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we = 1'b1;
                    if (in_last) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = IW'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    we    = 1'b1;
                    idx_d = '0;
                    if (in_last) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_RUN;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        err_d   = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (accept && in_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A done arriving on the final timer cycle still counts.
                if (done_sa2) begin
                    done_inc = 1'b1;
                    state_d  = ST_IDLE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            in_ready_q   <= 1'b0;
            active_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            launch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= (state_d != ST_RUN);
            active_q    <= (state_d == ST_RUN);
            busy_q      <= (state_d != ST_IDLE);
            frame_err_q <= err_d;
            if (done_inc) begin
                launch_cnt_q <= launch_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BEATS; i++) begin
            if (rst) begin
                ops_q[i] <= '0;
            end else if (we && (idx_q == IW'(i))) begin
                ops_q[i] <= in_data;
            end
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_a_row
        for (genvar c = 0; c < 4; c++) begin : g_a_col
            assign a_flat[a_index(r, c)*DW +: DW] = ops_q[a_index(r, c)];
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_b_row
        for (genvar c = 0; c < 3; c++) begin : g_b_col
            assign b_flat[(b_index(r, c) - N_A)*DW +: DW] = ops_q[b_index(r, c)];
        end
    end

    assign in_ready   = in_ready_q;
    assign active_sa2 = active_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign launch_cnt = launch_cnt_q;

endmodule

`default_nettype wire

// File: doc/sa2_operand_loader.md
# sa2_operand_loader

Producer-side front end for the 2x2 systolic array engine. It accepts a byte stream over a valid/ready handshake and fills the 16 data operands (a11..a44, row-major) and 9 filter operands (b11..b33, row-major). It then holds them stable, raises active_sa2 and keeps it high until the array returns done_sa2. Malformed frames are discarded with an error flag, and the array is never launched on partial operands.

## Interface
- DW, 8: operand width in bits.
- TIMEOUT, 64: maximum RUN cycles to wait for done_sa2 before aborting; must be ≥ 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  stream beat valid.
- in_data  in  DW  operand byte.
- in_last  in  1  final beat of frame.
- in_ready  out  1  loader accepts beat.
- a_flat  out  16*DW  data operands; a11 at [DW-1:0], a12 next, …, a44 at top.
- b_flat  out  9*DW  filter operands; b11 at [DW-1:0], …, b33 at top.
- active_sa2  out  1  launch/hold level to the array.
- done_sa2  in  1  completion from the array.
- busy  out  1  high in any state except IDLE.
- frame_err  out  1  one-cycle pulse on a framing error or timeout.
- launch_cnt  out  8  count of successful completions; wraps at 255→0.

## Operation
- States: IDLE, LOAD, RUN, FLUSH.
- Beat index idx: 0..24. Beats 0–15 load a11..a44; beats 16–24 load b11..b33. A beat is accepted when in_valid && in_ready.
- IDLE: in_ready=1. An accepted beat writes a11, sets idx=1 and moves to LOAD. If in_last is set on that beat, it is an error and the FSM goes to IDLE instead.
- LOAD: in_ready=1. Each accepted beat writes the operand at idx and increments idx.
  - in_last on beat 24: go to RUN.
  - in_last on any beat < 24: pulse frame_err, return to IDLE, operands partially overwritten, no launch.
  - Beat 24 without in_last: pulse frame_err, go to FLUSH.
- FLUSH: in_ready=1. Discard beats until an accepted beat with in_last, then go to IDLE.
- RUN: in_ready=0 and active_sa2=1. Operand registers are frozen.
  - done_sa2=1: increment launch_cnt, go to IDLE.
  - Timer reaches TIMEOUT with no done_sa2: pulse frame_err, go to IDLE.
- done_sa2 is ignored outside RUN.
- Operand registers hold their last written values in every state. They are not cleared on error.

## Timing
- Reset (synchronous, takes effect at the clk edge while rst=1):
  - Values: state=IDLE, idx=0, in_ready=0 during the reset cycle, all a_flat/b_flat=0, active_sa2=0, busy=0, frame_err=0, launch_cnt=0.
  - in_ready is 1 from the first cycle after rst falls.
- Reset mid-LOAD or mid-RUN: everything returns to the reset values and active_sa2 drops at that edge. An interrupted frame must be resent from beat 0.
- Latency:
  - active_sa2 rises on the edge that accepts beat 24. It is high in the first cycle after that beat.
  - Minimum frame: 25 cycles of load followed by 1 cycle of RUN.
- in_ready, active_sa2 and busy are registered, derived from state only. in_ready drops on the same edge that enters RUN, so no beat is accepted during RUN.
- done_sa2 sampled high in RUN: active_sa2 is 0 and in_ready is 1 on the next cycle. Back-to-back frames are therefore possible with one cycle of turnaround.
- Timeout timer: cleared on entry to RUN and incremented each RUN cycle. The abort happens when it equals TIMEOUT-1 and done_sa2=0. If done_sa2 arrives in the same cycle, done wins: no error.
- frame_err is registered and high for exactly one cycle, on the cycle after the offending edge.
- Gaps (in_valid=0) are allowed anywhere in a frame and do not advance idx.

## Structure
- Shared package sa_pkg holds:
  - the state encoding (IDLE/LOAD/RUN/FLUSH);
  - the constants N_A=16, N_B=9, N_BEATS=25;
  - the row-major index mapping functions used by both this loader and the array.
- Operand storage is a single 25-entry register file indexed by idx, sliced into a_flat/b_flat.
- No sub-module is needed beyond an optional sa_timeout_counter. That counter is reusable by the result-drain block.

## Test plan
- Normal frame: send bytes 1..25 with in_last on the 25th. Required response:
  - a_flat holds 1..16 and b_flat holds 17..25;
  - active_sa2 is high on the cycle after beat 25;
  - done_sa2 pulsed after 10 cycles → active_sa2 is 0 on the next cycle and launch_cnt=1.
- Backpressure gaps: same frame with in_valid toggled every other cycle. Required response: same operand values, and active_sa2 rises only after beat 25 is accepted.
- Early last: in_last on beat 10. Required response: frame_err one pulse, no active_sa2, state IDLE; a following good frame launches normally.
- Missing last: 30 beats with in_last on beat 30. Required response: frame_err after beat 25, beats 26–30 discarded, IDLE afterwards, launch_cnt unchanged.
- Timeout: valid frame with TIMEOUT=64 and done_sa2 never asserted. Required response: active_sa2 high for exactly 64 cycles, then frame_err pulse; done_sa2 sent late in IDLE is ignored.
- Reset mid-operation: rst during beat 12, and separately rst during RUN. Required response: all outputs at reset values the next cycle, active_sa2=0, launch_cnt=0.
